// File: rtl/batcharger_ctrl_fsm_if.sv
// Charger controller bus: request, ADC codes and thresholds in, power-stage enables and status out.
// The master side supplies measurements and thresholds, and the slave side is the controller.
interface batcharger_ctrl_fsm_if;
   logic       start;
   logic [7:0] vbat;
   logic [7:0] ibat;
   logic [7:0] vcv;
   logic [7:0] vtok;
   logic [7:0] vrech;
   logic [7:0] iend;
   logic [7:0] tmax;
   logic       en;
   logic       cc;
   logic       tc;
   logic       cv;
   logic       done;
   logic       fault;

   modport master (
      output start, vbat, ibat, vcv, vtok, vrech, iend, tmax,
      input  en, cc, tc, cv, done, fault
   );

   modport slave (
      input  start, vbat, ibat, vcv, vtok, vrech, iend, tmax,
      output en, cc, tc, cv, done, fault
   );
endinterface

// File: rtl/batcharger_ctrl_fsm.sv
// Li-ion charge controller: trickle / constant-current / constant-voltage sequencing with
// debounced phase exits, a phase timeout and registered Moore outputs to the power stage.
module batcharger_ctrl_fsm (
   input  logic                         clk,
   input  logic                         rst,
   batcharger_ctrl_fsm_if.slave         bus
);

   typedef enum logic [2:0] {IDLE, TC, CC, CV, DONE, FAULT} state_t;

   state_t      state_q, state_d, entry_state;
   logic [1:0]  qcnt_q, qcnt_d;
   logic [17:0] tcnt_q, tcnt_d;
   logic        cond, qualified, expired;
   logic        en_q, cc_q, tc_q, cv_q, done_q, fault_q;
   logic        en_d, cc_d, tc_d, cv_d, done_d, fault_d;

   // Phase selection on a fresh start or a recharge from DONE.
   always_comb begin
      entry_state = CV;
      if (bus.vbat < bus.vtok)
         entry_state = TC;
      else if (bus.vbat < bus.vcv)
         entry_state = CC;
   end

   // Next state, counters and output decode; the qualified exit is checked before the timeout.
   always_comb begin
      state_d = state_q;
      cond    = 1'b0;
      case (state_q)
         TC:      cond = (bus.vbat >= bus.vtok);
         CC:      cond = (bus.vbat >= bus.vcv);
         CV:      cond = (bus.ibat <= bus.iend);
         DONE:    cond = (bus.vbat < bus.vrech);
         default: cond = 1'b0;
      endcase
      qualified = cond && (qcnt_q == 2'd3);
      expired   = (bus.tmax != 8'd0) && (tcnt_q[17:10] == bus.tmax) && (tcnt_q[9:0] == 10'd0);

      case (state_q)
         IDLE:    if (bus.start) state_d = entry_state;
         TC:      if (qualified) state_d = CC;
                  else if (expired) state_d = FAULT;
         CC:      if (qualified) state_d = CV;
         CV:      if (qualified || expired) state_d = DONE;
         DONE:    if (qualified) state_d = entry_state;
         FAULT:   state_d = FAULT;
         default: state_d = IDLE;
      endcase
      if (!bus.start)
         state_d = IDLE;

      qcnt_d = cond ? qcnt_q + 2'd1 : 2'd0;
      tcnt_d = tcnt_q;
      if (((state_q == TC) || (state_q == CV)) && (tcnt_q != '1))
         tcnt_d = tcnt_q + 18'd1;
      if (state_d != state_q) begin
         qcnt_d = 2'd0;
         tcnt_d = 18'd0;
      end

      en_d    = 1'b0;
      cc_d    = 1'b0;
      tc_d    = 1'b0;
      cv_d    = 1'b0;
      done_d  = 1'b0;
      fault_d = 1'b0;
      case (state_d)
         TC:      begin en_d = 1'b1; tc_d = 1'b1; end
         CC:      begin en_d = 1'b1; cc_d = 1'b1; end
         CV:      begin en_d = 1'b1; cv_d = 1'b1; end
         DONE:    done_d  = 1'b1;
         FAULT:   fault_d = 1'b1;
         default: en_d    = 1'b0;
      endcase
   end

   // Outputs are registered from the next-state decode so they switch with the state, and reset drops them at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         qcnt_q  <= 2'd0;
         tcnt_q  <= 18'd0;
         en_q    <= 1'b0;
         cc_q    <= 1'b0;
         tc_q    <= 1'b0;
         cv_q    <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         qcnt_q  <= qcnt_d;
         tcnt_q  <= tcnt_d;
         en_q    <= en_d;
         cc_q    <= cc_d;
         tc_q    <= tc_d;
         cv_q    <= cv_d;
         done_q  <= done_d;
         fault_q <= fault_d;
      end
   end

   assign bus.en    = en_q;
   assign bus.cc    = cc_q;
   assign bus.tc    = tc_q;
   assign bus.cv    = cv_q;
   assign bus.done  = done_q;
   assign bus.fault = fault_q;

endmodule

// File: tb/tb_batcharger_ctrl_fsm.sv
// Directed bench for the charge controller; outputs are compared as {en,cc,tc,cv,done,fault}.
module tb_batcharger_ctrl_fsm;

   localparam logic [5:0] O_IDLE  = 6'b000000;
   localparam logic [5:0] O_TC    = 6'b101000;
   localparam logic [5:0] O_CC    = 6'b110000;
   localparam logic [5:0] O_CV    = 6'b100100;
   localparam logic [5:0] O_DONE  = 6'b000010;
   localparam logic [5:0] O_FAULT = 6'b000001;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   batcharger_ctrl_fsm_if bus_if ();

   batcharger_ctrl_fsm dut (
      .clk (clk),
      .rst (rst),
      .bus (bus_if)
   );

   // Free-running clock with rising edges at odd multiples of 5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [5:0] outs();
      return {bus_if.en, bus_if.cc, bus_if.tc, bus_if.cv, bus_if.done, bus_if.fault};
   endfunction

   task automatic checkOutput(input string tag, input logic [5:0] actual, input logic [5:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got %b expected %b", tag, actual, expected);
      end
   endtask

   task automatic applyStimulus(input logic st, input logic [7:0] vb, input logic [7:0] ib);
      bus_if.start = st;
      bus_if.vbat  = vb;
      bus_if.ibat  = ib;
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      total        = 0;
      bad          = 0;
      rst          = 1'b1;
      bus_if.vcv   = 8'd188;
      bus_if.vtok  = 8'd154;
      bus_if.vrech = 8'd179;
      bus_if.iend  = 8'd13;
      bus_if.tmax  = 8'd0;
      applyStimulus(1'b0, 8'd120, 8'd200);

      #12;
      checkOutput("reset", outs(), O_IDLE);
      step(1);
      rst = 1'b0;
      step(1);
      checkOutput("idle_hold", outs(), O_IDLE);

      // Full charge sequence without timeout.
      applyStimulus(1'b1, 8'd120, 8'd200);
      step(1);
      checkOutput("enter_tc", outs(), O_TC);
      applyStimulus(1'b1, 8'd160, 8'd200);
      step(3);
      checkOutput("tc_3edges", outs(), O_TC);
      step(1);
      checkOutput("tc_to_cc", outs(), O_CC);
      applyStimulus(1'b1, 8'd190, 8'd200);
      step(3);
      checkOutput("cc_3edges", outs(), O_CC);
      step(1);
      checkOutput("cc_to_cv", outs(), O_CV);
      applyStimulus(1'b1, 8'd190, 8'd10);
      step(3);
      checkOutput("cv_3edges", outs(), O_CV);
      step(1);
      checkOutput("cv_to_done", outs(), O_DONE);

      // Recharge: 170 is at or above vtok and below vcv, so re-entry is CC.
      applyStimulus(1'b1, 8'd170, 8'd10);
      step(3);
      checkOutput("done_3edges", outs(), O_DONE);
      step(1);
      checkOutput("recharge_cc", outs(), O_CC);

      // Debounce: a one-edge dropout restarts the qualification count.
      applyStimulus(1'b1, 8'd190, 8'd200);
      step(3);
      checkOutput("deb_run1", outs(), O_CC);
      applyStimulus(1'b1, 8'd180, 8'd200);
      step(1);
      checkOutput("deb_gap", outs(), O_CC);
      applyStimulus(1'b1, 8'd190, 8'd200);
      step(3);
      checkOutput("deb_run2_3", outs(), O_CC);
      step(1);
      checkOutput("deb_run2_4", outs(), O_CV);

      // Abort from CV.
      applyStimulus(1'b0, 8'd190, 8'd200);
      step(1);
      checkOutput("abort_cv", outs(), O_IDLE);

      // Direct CV entry.
      applyStimulus(1'b1, 8'd200, 8'd200);
      step(1);
      checkOutput("direct_cv", outs(), O_CV);
      applyStimulus(1'b0, 8'd200, 8'd200);
      step(1);
      checkOutput("direct_cv_abort", outs(), O_IDLE);

      // Asynchronous reset mid-charge, then immediate restart on the first edge.
      applyStimulus(1'b1, 8'd170, 8'd200);
      step(1);
      checkOutput("pre_rst_cc", outs(), O_CC);
      #1 rst = 1'b1;
      #1 checkOutput("async_rst", outs(), O_IDLE);
      #1 rst = 1'b0;
      step(1);
      checkOutput("post_rst_cc", outs(), O_CC);
      applyStimulus(1'b0, 8'd170, 8'd200);
      step(1);
      checkOutput("post_rst_idle", outs(), O_IDLE);

      // Trickle timeout with tmax=2: 2048 counting edges, then FAULT on the next.
      bus_if.tmax = 8'd2;
      applyStimulus(1'b1, 8'd100, 8'd200);
      step(1);
      checkOutput("to_tc_entry", outs(), O_TC);
      step(2048);
      checkOutput("to_tc_2048", outs(), O_TC);
      step(1);
      checkOutput("to_fault", outs(), O_FAULT);
      applyStimulus(1'b1, 8'd200, 8'd200);
      step(1);
      checkOutput("fault_sticky", outs(), O_FAULT);
      applyStimulus(1'b0, 8'd200, 8'd200);
      step(1);
      checkOutput("fault_exit", outs(), O_IDLE);

      // Coincident expiry and qualified TC->CC: the transition to CC wins.
      applyStimulus(1'b1, 8'd100, 8'd200);
      step(1);
      checkOutput("prio_tc_entry", outs(), O_TC);
      step(2045);
      applyStimulus(1'b1, 8'd160, 8'd200);
      step(3);
      checkOutput("prio_tc_hold", outs(), O_TC);
      step(1);
      checkOutput("prio_cc", outs(), O_CC);
      applyStimulus(1'b0, 8'd160, 8'd200);
      step(1);

      // CV timeout with tmax=1 ends in DONE even though ibat stays high.
      bus_if.tmax = 8'd1;
      applyStimulus(1'b1, 8'd200, 8'd200);
      step(1);
      checkOutput("cvto_entry", outs(), O_CV);
      step(1024);
      checkOutput("cvto_1024", outs(), O_CV);
      step(1);
      checkOutput("cvto_done", outs(), O_DONE);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/batcharger_ctrl_fsm.md
BATCHARGER_CTRL_FSM -- requirements
Module: batcharger_ctrl_fsm

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset. The ports SHALL be named clk and rst.
REQ-002 clk  in  1  Controller clock; all state updates on the rising edge.
REQ-003 rst  in  1  Asynchronous active-high reset.
REQ-004 start  in  1  Charge request; level-sensitive.
REQ-005 vbat  in  8  Battery voltage ADC code, same scale as vcv: code = 51*V.
REQ-006 ibat  in  8  Battery current ADC code; 255 equals 1C.
REQ-007 vcv  in  8  CV target code; also the CC-to-CV threshold.
REQ-008 vtok  in  8  Trickle-to-CC threshold code.
REQ-009 vrech  in  8  Recharge threshold code, used in DONE.
REQ-010 iend  in  8  End-of-charge current code.
REQ-011 tmax  in  8  Timeout in units of 1024 clk cycles; 0 disables the timeout.
REQ-012 en, cc, tc, cv  out  1 each  Drive the power stage enables directly.
REQ-013 done, fault  out  1 each  Status flags.

Function
REQ-014 The block SHALL implement states IDLE, TC, CC, CV, DONE and FAULT, held in a state register.
REQ-015 Outputs SHALL be registered Moore decodes that change on the same edge as the state:
- IDLE: all outputs 0.
- TC: en=1, tc=1.
- CC: en=1, cc=1.
- CV: en=1, cv=1.
- DONE: done=1, all others 0.
- FAULT: fault=1, all others 0.
REQ-016 At most one of cc/tc/cv SHALL be 1 at any time, and none SHALL be 1 when en=0.
REQ-017 IDLE with start=1 SHALL transition after one edge, with no qualification, to:
- TC if vbat<vtok;
- else CC if vbat<vcv;
- else CV.
REQ-018 Exit conditions (all comparisons unsigned, 8-bit):
- TC->CC on vbat>=vtok.
- CC->CV on vbat>=vcv.
- CV->DONE on ibat<=iend.
- DONE->(REQ-017 decision) on vbat<vrech.
REQ-019 Each REQ-018 condition SHALL be qualified by a 2-bit counter:
- The counter increments on edges where the condition is true and clears to 0 on any edge where it is false.
- The transition occurs on the 4th consecutive qualifying edge.
- The counter clears on every state change.
REQ-020 The timeout counter SHALL behave as follows:
- It is an 18-bit counter that clears on every state change and increments every cycle in TC and CV only.
- It saturates rather than wrapping.
- It expires when tmax!=0 and counter[17:10]==tmax and counter[9:0]==0.
REQ-021 Timeout expiry in TC SHALL go to FAULT on the next edge. Expiry in CV SHALL go to DONE on the next edge, regardless of ibat.
REQ-022 If expiry and a qualified REQ-018 transition occur on the same edge, the REQ-018 transition SHALL take priority, except in TC, where the TC->CC transition wins.
REQ-023 start=0 in any state SHALL force IDLE on the next edge, overriding all other transitions.
REQ-024 FAULT SHALL be exited only via start=0.
REQ-025 A change of vcv, vtok, vrech, iend or tmax mid-operation SHALL take effect on the next comparison without resetting the counters.

Reset
REQ-026 While rst=1, the block SHALL hold the following values:
- state=IDLE;
- en=cc=tc=cv=done=fault=0;
- both counters=0.
REQ-027 Reset asserted mid-charge SHALL drop en asynchronously, without waiting for clk.
REQ-028 After rst deasserts, the first possible transition SHALL be on the first clk edge, per REQ-017.

Verification
REQ-029 Full charge sequence. Stimulus: vcv=188, vtok=154, iend=13, tmax=0, start=1, vbat=120. Required response:
- TC (en=1, tc=1) one edge after start.
- After vbat=160 held 4 edges, CC.
- After vbat=190 held 4 edges, CV.
- After ibat=10 held 4 edges, DONE with done=1 and en=0.
REQ-030 Debounce. Stimulus: in CC, vbat=190 for 3 edges, then 180 for 1 edge, then 190 for 4 edges. Required response: remains CC until the 4th edge of the second run, then CV.
REQ-031 Trickle timeout. Stimulus: tmax=2, vbat stays 100. Required response: FAULT exactly 2049 cycles after TC entry (2048 counting cycles plus the transition edge); fault=1, en=0; start=0 returns to IDLE.
REQ-032 Recharge. Stimulus: in DONE with vrech=179, vbat drops to 170 for 4 edges. Required response: re-enters CC (170>=vtok, <vcv).
REQ-033 Abort and reset. Stimulus 1: in CV, start=0. Required response: IDLE next edge, all outputs 0. Stimulus 2: in CC, rst pulsed between edges. Required response: en=0 immediately and state IDLE.
REQ-034 Direct CV entry. Stimulus: start=1 with vbat=200 and vcv=188. Required response: CV after one edge; cc=tc=0.
